dec_scan_ctrl: RTL

//  Upstream sequencer for the 3-to-8 decoder: produces the 3-bit select (in) and enable (en).

---
 rtl/dec_pkg.sv | 15 +
 rtl/dec_scan_prescaler.sv | 29 ++
 rtl/dec_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the 3-to-8 decoder scan sequencer.
package dec_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 8;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/dec_scan_prescaler.sv
// Dwell-time down-counter: load has priority, decrements while enabled,
// holds at zero, and flags terminal count combinationally from the register.
module dec_scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc
);

    logic [DIV_W-1:0] count;

    // Load a new dwell length or count down towards zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer driving the select/enable of a 3-to-8 decoder.
// Walks digits 0..last_sel, holding each for div+1 cycles.
// Build option SCAN_BLANK_EN: when defined, a BLANK_CYC-cycle gap with
// sel_en low separates digits; when undefined, sel advances directly and
// sel_en stays high across digits.
module dec_scan_ctrl
    import dec_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             single,
    input  logic [SEL_W-1:0] last_sel,
    input  logic [DIV_W-1:0] div,
    output logic [SEL_W-1:0] sel,
    output logic             sel_en,
    output logic             frame_done,
    output logic             busy
);

    if (BLANK_CYC < 1) begin : g_bad_blank_cyc
        $error("BLANK_CYC must be at least 1");
    end

    state_t           state;
    sel_t             last_lat;
    logic [DIV_W-1:0] div_lat;
    logic             single_lat;

    logic             accept;
    logic             step;
    logic             frame_end;
    logic             reload;
    logic [DIV_W-1:0] load_val;
    logic             dwell_tc;

`ifdef SCAN_BLANK_EN
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    logic [BW-1:0] blank_cnt;
`endif

    // Decide when the dwell counter must be (re)loaded for a new digit.
    always_comb begin
        accept = (state == ST_IDLE) && start && !stop;
`ifdef SCAN_BLANK_EN
        step = (state == ST_BLANK) && (blank_cnt == '0);
`else
        step = (state == ST_DWELL) && dwell_tc;
`endif
        frame_end = (sel == last_lat);
        reload    = accept || (step && !stop && !(frame_end && single_lat));
        load_val  = (state == ST_IDLE) ? div : div_lat;
    end

    dec_scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (reload),
        .en       (state == ST_DWELL),
        .load_val (load_val),
        .tc       (dwell_tc)
    );

    // Scan FSM with registered outputs; stop overrides everything but reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            last_lat   <= '0;
            div_lat    <= '0;
            single_lat <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_cnt  <= '0;
`endif
        end else if (stop) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_lat   <= last_sel;
                        div_lat    <= div;
                        single_lat <= single;
                        state      <= ST_DWELL;
                        sel        <= '0;
                        sel_en     <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (dwell_tc) begin
`ifdef SCAN_BLANK_EN
                        state     <= ST_BLANK;
                        sel_en    <= 1'b0;
                        blank_cnt <= BW'(BLANK_CYC - 1);
`else
                        if (!frame_end) begin
                            sel <= sel + 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            sel        <= '0;
                            if (single_lat) begin
                                state  <= ST_IDLE;
                                sel_en <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end
`endif
                    end
                end
`ifdef SCAN_BLANK_EN
                ST_BLANK: begin
                    if (blank_cnt != '0) begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end else if (!frame_end) begin
                        state  <= ST_DWELL;
                        sel    <= sel + 1'b1;
                        sel_en <= 1'b1;
                    end else begin
                        frame_done <= 1'b1;
                        sel        <= '0;
                        if (single_lat) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= ST_DWELL;
                            sel_en <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    sel    <= '0;
                    sel_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
